fsmc_master: RTL and testbench

FSMC_MASTER -- requirements
Module: fsmc_master

---
 rtl/fsmc_master.sv | 191 +++++++++++++++++++
 tb/tb_fsmc_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_master.sv
// FSMC-style asynchronous SRAM/peripheral bus master: runs one 32-bit
// transfer as two 16-bit bus cycles (lower half, then upper half).
// Parameters: ADDSET, DATAST, HOLD, TURN (cycles per phase, 1..255).
// Ports: clk, rst (async, active-high); host side cmd_valid/cmd_ready,
//   cmd_write, cmd_addr[15:0], cmd_data[31:0], rd_data[31:0], done;
//   bus side fsmc_adr[15:0], fsmc_dat[15:0] (inout), fsmc_ce_n,
//   fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n.
// Optional: define FSMC_MASTER_NWAIT_EN to add fsmc_wait_n, which
//   stretches STROBE while low.
module fsmc_master #(
    parameter int ADDSET = 1,
    parameter int DATAST = 3,
    parameter int HOLD   = 1,
    parameter int TURN   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic [31:0] rd_data,
    output logic        done,
    output logic [15:0] fsmc_adr,
    inout  wire  [15:0] fsmc_dat,
    output logic        fsmc_ce_n,
    output logic        fsmc_we_n,
    output logic        fsmc_oe_n,
    output logic        fsmc_ub_n,
`ifdef FSMC_MASTER_NWAIT_EN
    output logic        fsmc_lb_n,
    input  logic        fsmc_wait_n
`else
    output logic        fsmc_lb_n
`endif
);

    localparam logic [7:0] C_ADDSET = 8'(ADDSET);
    localparam logic [7:0] C_DATAST = 8'(DATAST);
    localparam logic [7:0] C_HOLD   = 8'(HOLD);
    localparam logic [7:0] C_TURN   = 8'(TURN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_TURN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rd_q;
    logic        accept;
    logic        sample;
    logic        drv;
    logic        last;
    logic        strobe_go;
    logic [15:0] half;

`ifdef FSMC_MASTER_NWAIT_EN
    // A stalled target freezes the STROBE count; only ready cycles count.
    assign strobe_go = fsmc_wait_n;
`else
    assign strobe_go = 1'b1;
`endif

    assign last     = (cnt_q == 8'd1);
    assign half     = phase_q ? data_q[31:16] : data_q[15:0];
    assign fsmc_dat = drv ? half : 16'hzzzz;
    assign fsmc_adr = addr_q;
    assign rd_data  = rd_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        accept    = 1'b0;
        sample    = 1'b0;
        drv       = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        fsmc_ce_n = 1'b1;
        fsmc_we_n = 1'b1;
        fsmc_oe_n = 1'b1;
        fsmc_ub_n = 1'b1;
        fsmc_lb_n = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    phase_d = 1'b0;
                    cnt_d   = C_ADDSET;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                fsmc_ce_n = 1'b0;
                fsmc_ub_n = ~phase_q;
                fsmc_lb_n = phase_q;
                drv       = wr_q;
                if (last) begin
                    cnt_d   = C_DATAST;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STROBE: begin
                fsmc_ce_n = 1'b0;
                fsmc_ub_n = ~phase_q;
                fsmc_lb_n = phase_q;
                fsmc_we_n = ~wr_q;
                fsmc_oe_n = wr_q;
                drv       = wr_q;
                if (strobe_go) begin
                    if (last) begin
                        sample  = ~wr_q;
                        cnt_d   = C_HOLD;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_HOLD: begin
                fsmc_ce_n = 1'b0;
                fsmc_ub_n = ~phase_q;
                fsmc_lb_n = phase_q;
                drv       = wr_q;
                if (last) begin
                    cnt_d   = C_TURN;
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_TURN: begin
                if (last) begin
                    if (phase_q) begin
                        state_d = S_DONE;
                    end else begin
                        phase_d = 1'b1;
                        cnt_d   = C_ADDSET;
                        state_d = S_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 16'd0;
            data_q  <= 32'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            if (accept) begin
                wr_q   <= cmd_write;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
            end
            if (sample) begin
                if (phase_q) rd_q[31:16] <= fsmc_dat;
                else         rd_q[15:0]  <= fsmc_dat;
            end
        end
    end

endmodule

// File: tb/tb_fsmc_master.sv
// Self-checking bench for fsmc_master: default-parameter instance with a
// scoreboard/bus monitor, plus an all-ones timing instance.
module tb_fsmc_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready;
    logic [31:0] rd_data;
    logic        done;
    logic [15:0] fsmc_adr;
    wire  [15:0] fsmc_dat;
    logic        fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n;
    logic [15:0] rd_lo = 16'd0;
    logic [15:0] rd_hi = 16'd0;

    logic        f_valid = 1'b0;
    logic        f_ready, f_done;
    logic [31:0] f_rd;
    logic [15:0] f_adr;
    wire  [15:0] f_dat;
    logic        f_ce_n, f_we_n, f_oe_n, f_ub_n, f_lb_n;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_done = -1;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        int          t;
    } exp_t;
    exp_t sb[$];
    int lo_cnt, hi_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus model: the target drives the selected half while oe_n is low.
    assign fsmc_dat = !fsmc_oe_n ? (fsmc_ub_n ? rd_lo : rd_hi) : 16'hzzzz;

    fsmc_master u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rd_data(rd_data), .done(done),
        .fsmc_adr(fsmc_adr), .fsmc_dat(fsmc_dat),
        .fsmc_ce_n(fsmc_ce_n), .fsmc_we_n(fsmc_we_n),
        .fsmc_oe_n(fsmc_oe_n), .fsmc_ub_n(fsmc_ub_n),
        .fsmc_lb_n(fsmc_lb_n)
    );

    fsmc_master #(.ADDSET(1), .DATAST(1), .HOLD(1), .TURN(1)) u_fast (
        .clk(clk), .rst(rst),
        .cmd_valid(f_valid), .cmd_ready(f_ready),
        .cmd_write(1'b1), .cmd_addr(16'h0100), .cmd_data(32'h11223344),
        .rd_data(f_rd), .done(f_done),
        .fsmc_adr(f_adr), .fsmc_dat(f_dat),
        .fsmc_ce_n(f_ce_n), .fsmc_we_n(f_we_n),
        .fsmc_oe_n(f_oe_n), .fsmc_ub_n(f_ub_n),
        .fsmc_lb_n(f_lb_n)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Bus monitor and scoreboard for the default instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (sb.size() > 0) begin
                e = sb[0];
                if (!fsmc_ce_n) chk("adr", {16'd0, fsmc_adr}, {16'd0, e.addr});
                if (!fsmc_we_n) begin
                    chk("we_dat", {16'd0, fsmc_dat},
                        {16'd0, fsmc_ub_n ? e.data[15:0] : e.data[31:16]});
                    chk("we_bytes", {30'd0, fsmc_ub_n, fsmc_lb_n},
                        fsmc_ub_n ? 32'd2 : 32'd1);
                end
                if (!fsmc_we_n || !fsmc_oe_n) begin
                    if (fsmc_ub_n) lo_cnt++;
                    else           hi_cnt++;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.t, 32'd13);
                    chk("strobe_lo", lo_cnt, 32'd3);
                    chk("strobe_hi", hi_cnt, 32'd3);
                    if (!e.wr) chk("rd_data", rd_data, e.data);
                end
                last_done = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                sb.push_back('{cmd_write, cmd_addr,
                               cmd_write ? cmd_data : {rd_hi, rd_lo}, cyc});
                lo_cnt = 0;
                hi_cnt = 0;
            end
        end
    end

    task automatic drive(input logic wr, input logic [15:0] a,
                         input logic [31:0] d);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) ok = 1;
        end
        chk(tag, ok, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        chk(tag, ok, 32'd1);
    endtask

    initial begin
        int ok, seen, c, we, ce, acc2;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_strobes", {27'd0, fsmc_ce_n, fsmc_we_n, fsmc_oe_n,
                            fsmc_ub_n, fsmc_lb_n}, 32'h1f);
        chk("rst_adr", {16'd0, fsmc_adr}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Lower/upper halves of a write.
        @(posedge clk); #2 drive(1'b1, 16'h0010, 32'hDEADBEEF);
        wait_accept("acc_w1");
        @(posedge clk); #2 cmd_valid = 1'b0;
        wait_done("done_w1");

        // Read with the bus model supplying both halves.
        rd_lo = 16'h5678;
        rd_hi = 16'h1234;
        @(posedge clk); #2 drive(1'b0, 16'h0020, 32'h0);
        wait_accept("acc_r1");
        @(posedge clk); #2 cmd_valid = 1'b0;
        wait_done("done_r1");
        repeat (3) @(negedge clk);
        chk("rd_held", rd_data, 32'h12345678);

        // Back-to-back with cmd_valid held high.
        rd_lo = 16'h9ABC;
        rd_hi = 16'hDEF0;
        @(posedge clk); #2 drive(1'b1, 16'h0040, 32'hA5A50F0F);
        wait_accept("acc_b1");
        @(posedge clk); #2 drive(1'b0, 16'h0044, 32'h0);
        wait_accept("acc_b2");
        acc2 = cyc;
        chk("b2b_gap", acc2, last_done + 1);
        @(posedge clk); #2 cmd_valid = 1'b0;
        wait_done("done_b2");

        // Requests during a transfer are ignored.
        @(posedge clk); #2 drive(1'b1, 16'h0050, 32'h76543210);
        wait_accept("acc_ign");
        @(posedge clk); #2 drive(1'b1, 16'h0BAD, 32'hFFFFFFFF);
        @(negedge clk);
        chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #2 cmd_valid = 1'b0;
        wait_done("done_ign");

        // Reset during the upper strobe of a write.
        @(posedge clk); #2 drive(1'b1, 16'h0077, 32'hCAFEF00D);
        wait_accept("acc_rst");
        @(posedge clk); #2 cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            @(negedge clk);
            if (!fsmc_we_n && !fsmc_ub_n) ok = 1;
        end
        chk("find_upper_strobe", ok, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_strobes", {27'd0, fsmc_ce_n, fsmc_we_n, fsmc_oe_n,
                                  fsmc_ub_n, fsmc_lb_n}, 32'h1f);
        chk("async_rst_adr", {16'd0, fsmc_adr}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("no_done_after_rst", seen, 32'd0);

        @(posedge clk); #2 drive(1'b1, 16'h0055, 32'h01234567);
        wait_accept("acc_post_rst");
        @(posedge clk); #2 cmd_valid = 1'b0;
        wait_done("done_post_rst");

        // All-ones timing: 9-cycle latency, one cycle per state.
        @(posedge clk); #2 f_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && ok == 0; i++) begin
            @(negedge clk);
            if (f_valid && f_ready) ok = 1;
        end
        chk("acc_fast", ok, 32'd1);
        @(posedge clk); #2 f_valid = 1'b0;
        c = 0; we = 0; ce = 0; ok = 0;
        while (ok == 0 && c < 30) begin
            @(negedge clk);
            c++;
            if (!f_we_n) we++;
            if (!f_ce_n) ce++;
            if (f_done) ok = 1;
        end
        chk("fast_latency", c, 32'd9);
        chk("fast_we_cycles", we, 32'd2);
        chk("fast_ce_cycles", ce, 32'd6);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
